// File: rtl/mux_arb4.sv
// mux_arb4: four-requester round-robin arbiter in front of a registered 4:1
// data mux. Each grant covers a burst of up to BURST beats, and back-pressure
// from o_rdy is honoured.
// Optional feature macro: MUX_ARB4_LOCK_EN adds the lock port. While
// lock[sel] is set, the burst runs until the owner drops its request.
module mux_arb4 #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             o_rdy,
`ifdef MUX_ARB4_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] o,
  output logic             o_vld
);

  localparam int CNT_W = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n, sel_n, winner;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             beat, burst_end, locked;
  logic [WIDTH-1:0] sel_data;

`ifdef MUX_ARB4_LOCK_EN
  assign locked = lock[sel];
`else
  assign locked = 1'b0;
`endif

  // Round-robin pick. Offsets are scanned from farthest to nearest, so the
  // first requester at or after ptr is the one left standing.
  always_comb begin
    logic [1:0] idx;
    winner = ptr;
    idx    = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(3 - k);
      if (req[idx]) winner = idx;
    end
  end

  // Shared 4:1 data select.
  always_comb begin
    case (sel)
      2'd0:    sel_data = a;
      2'd1:    sel_data = b;
      2'd2:    sel_data = c;
      default: sel_data = d;
    endcase
  end

  // Next-state logic, grant/ack decode and burst termination.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    cnt_n     = cnt;
    gnt       = '0;
    ack       = '0;
    burst_end = 1'b0;
    beat      = (state == BUSY) && req[sel] && (!o_vld || o_rdy);
    case (state)
      IDLE: begin
        if (|req) begin
          sel_n   = winner;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        gnt[sel] = 1'b1;
        if (beat) begin
          ack[sel] = 1'b1;
          // Saturate so a long locked burst cannot wrap the count.
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        end
        // A request drop ends the burst, even if a beat would have happened.
        if (!req[sel]) burst_end = 1'b1;
        else if (beat && !locked && cnt >= CNT_LAST) burst_end = 1'b1;
        if (burst_end) begin
          state_n = IDLE;
          ptr_n   = sel + 2'd1;
        end
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
    end
  end

  // Output register. It holds under back-pressure and clears once the beat
  // has been consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o     <= '0;
      o_vld <= 1'b0;
    end else if (beat) begin
      o     <= sel_data;
      o_vld <= 1'b1;
    end else if (o_rdy) begin
      o_vld <= 1'b0;
    end
  end

endmodule
